// File: rtl/mdiv_unit_pkg.sv
// Shared constants, FSM encoding and helpers for the iterative divider.
// Signed support is compiled in by the MDIV_SIGNED_EN macro.
package mdiv_unit_pkg;

  localparam int unsigned OpWidth     = 32;
  localparam int unsigned ResultWidth = 64;
  localparam int unsigned DivIters    = 32;
  localparam int unsigned CntWidth    = 6;

  localparam logic Enable = 1'b1;
  localparam logic Stop   = 1'b0;

  typedef enum logic [1:0] {
    StFree   = 2'b00,
    StByZero = 2'b01,
    StOn     = 2'b10,
    StEnd    = 2'b11
  } div_state_e;

  function automatic logic [OpWidth-1:0] cond_neg(input logic neg, input logic [OpWidth-1:0] val);
    return neg ? ((~val) + OpWidth'(1)) : val;
  endfunction

endpackage

// File: rtl/mdiv_unit_if.sv
// EX-stage <-> divider handshake bundle. master = pipeline side, slave = divider.
interface mdiv_unit_if;

  logic                                    start;
  logic                                    annul;
  logic                                    signed_div;
  logic [mdiv_unit_pkg::OpWidth-1:0]       opdata1;
  logic [mdiv_unit_pkg::OpWidth-1:0]       opdata2;
  logic [mdiv_unit_pkg::ResultWidth-1:0]   result;
  logic                                    ready;
  logic                                    stall_req;

  modport master (
    output start, annul, signed_div, opdata1, opdata2,
    input  result, ready, stall_req
  );

  modport slave (
    input  start, annul, signed_div, opdata1, opdata2,
    output result, ready, stall_req
  );

endinterface

// File: rtl/mdiv_unit.sv
// Multi-cycle restoring divider: 32 shift-subtract steps, result = {remainder, quotient}.
// Define MDIV_SIGNED_EN to honour signed_div; otherwise every operation is unsigned.
module mdiv_unit
  import mdiv_unit_pkg::*;
(
  input logic        clk,
  input logic        rst,
  mdiv_unit_if.slave bus
);

  div_state_e                 state_q, state_d;
  logic [CntWidth-1:0]        cnt_q, cnt_d;
  logic [2*OpWidth:0]         work_q, work_d;
  logic [OpWidth-1:0]         divisor_q, divisor_d;
  logic [ResultWidth-1:0]     result_q, result_d;
  logic                       ready_q, ready_d;

  logic [OpWidth:0]           diff;
  logic [OpWidth-1:0]         op1_mag, op2_mag, quot_fin, rem_fin;

`ifdef MDIV_SIGNED_EN
  logic                       neg_quot_q, neg_quot_d;
  logic                       neg_rem_q, neg_rem_d;
`else
  logic                       unused_signed_div;
  assign unused_signed_div = bus.signed_div;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    ready_d   = ready_q;

    diff = {1'b0, work_q[63:32]} - {1'b0, divisor_q};

`ifdef MDIV_SIGNED_EN
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    op1_mag    = cond_neg(bus.signed_div & bus.opdata1[31], bus.opdata1);
    op2_mag    = cond_neg(bus.signed_div & bus.opdata2[31], bus.opdata2);
    quot_fin   = cond_neg(neg_quot_q, work_q[31:0]);
    rem_fin    = cond_neg(neg_rem_q, work_q[64:33]);
`else
    op1_mag    = bus.opdata1;
    op2_mag    = bus.opdata2;
    quot_fin   = work_q[31:0];
    rem_fin    = work_q[64:33];
`endif

    unique case (state_q)
      StFree: begin
        ready_d = Stop;
        if (bus.start && !bus.annul) begin
          if (bus.opdata2 == '0) begin
            state_d = StByZero;
          end else begin
            state_d   = StOn;
            cnt_d     = '0;
            work_d    = {{OpWidth{1'b0}}, op1_mag, 1'b0};
            divisor_d = op2_mag;
`ifdef MDIV_SIGNED_EN
            neg_quot_d = bus.signed_div & (bus.opdata1[31] ^ bus.opdata2[31]);
            neg_rem_d  = bus.signed_div & bus.opdata1[31];
`endif
          end
        end
      end
      StByZero: begin
        result_d = '0;
        state_d  = StEnd;
      end
      StOn: begin
        if (cnt_q == CntWidth'(DivIters)) begin
          result_d = {rem_fin, quot_fin};
          state_d  = StEnd;
        end else begin
          // Keep the shifted partial remainder only when the trial subtract went negative.
          if (diff[OpWidth]) begin
            work_d = {work_q[63:0], 1'b0};
          end else begin
            work_d = {diff[31:0], work_q[31:0], 1'b1};
          end
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      StEnd: begin
        if (bus.start) begin
          ready_d = Enable;
        end else begin
          ready_d = Stop;
          state_d = StFree;
        end
      end
      default: state_d = StFree;
    endcase

    if (bus.annul) begin
      state_d = StFree;
      ready_d = Stop;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFree;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
      ready_q    <= Stop;
`ifdef MDIV_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
`ifdef MDIV_SIGNED_EN
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign bus.result    = result_q;
  assign bus.ready     = ready_q;
  assign bus.stall_req = bus.start & ~ready_q & ~bus.annul;

endmodule

// File: tb/tb_mdiv_unit.sv
// Directed bench for mdiv_unit: latency, stall window, signed/unsigned results, annul and reset.
module tb_mdiv_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mdiv_unit_if bus ();

  mdiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one operation, hold start until the result is seen, then release it.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
    int lat;
    int stalls;
    lat    = 0;
    stalls = 0;
    bus.signed_div = sgn;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.start      = 1'b1;
    #1;
    if (bus.stall_req) stalls++;
    step();
    bus.opdata1 = ~a;
    bus.opdata2 = 32'h0000_0005;
    #1;
    for (int i = 0; i < 60; i++) begin
      if (bus.ready) break;
      if (bus.stall_req) stalls++;
      step();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_lat + 1));
    chk({tag, "_result"}, bus.result, exp_res);
    chk({tag, "_stall_low_when_ready"}, 64'(bus.stall_req), 64'd0);
    step();
    chk({tag, "_ready_held"}, 64'(bus.ready), 64'd1);
    chk({tag, "_result_held"}, bus.result, exp_res);
    bus.start = 1'b0;
    step();
    chk({tag, "_ready_drop"}, 64'(bus.ready), 64'd0);
  endtask

  initial begin
    int ready_seen;
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.annul      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    step();
    step();
    chk("reset_ready", 64'(bus.ready), 64'd0);
    chk("reset_result", bus.result, 64'd0);
    chk("reset_stall", 64'(bus.stall_req), 64'd0);
    rst = 1'b0;
    step();

    run_div("u_100_7", 1'b0, 32'd100, 32'd7, 34, {32'd2, 32'd14});

`ifdef MDIV_SIGNED_EN
    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 34, {32'd1, 32'hFFFF_FFFD});
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, {32'd0, 32'h8000_0000});
`else
    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34, {32'd1, 32'h7FFF_FFFC});
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 34, {32'd7, 32'd0});
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, {32'h8000_0000, 32'd0});
`endif

    run_div("u_by_zero", 1'b0, 32'h1234_5678, 32'd0, 2, 64'd0);

    // Annul at cnt==10: acceptance edge plus ten step edges.
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'h1234_5678;
    bus.opdata2    = 32'd3;
    bus.start      = 1'b1;
    step();
    for (int i = 0; i < 10; i++) step();
    bus.annul = 1'b1;
    #1;
    chk("annul_stall_low", 64'(bus.stall_req), 64'd0);
    step();
    bus.annul = 1'b0;
    bus.start = 1'b0;
    #1;
    chk("annul_ready_low", 64'(bus.ready), 64'd0);
    step();
    run_div("u_after_annul", 1'b0, 32'hFFFF_FFFF, 32'd1, 34, {32'd0, 32'hFFFF_FFFF});

    // Reset mid-operation: outputs clear and no late ready pulse appears.
    bus.opdata1 = 32'd1000;
    bus.opdata2 = 32'd9;
    bus.start   = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    rst       = 1'b1;
    bus.start = 1'b0;
    step();
    chk("rst_mid_ready", 64'(bus.ready), 64'd0);
    chk("rst_mid_result", bus.result, 64'd0);
    chk("rst_mid_stall", 64'(bus.stall_req), 64'd0);
    rst = 1'b0;
    ready_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.ready) ready_seen++;
    end
    chk("rst_mid_no_ready", 64'(ready_seen), 64'd0);

    run_div("u_after_rst", 1'b0, 32'd1000, 32'd9, 34, {32'd1, 32'd111});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
